// File: rtl/cmp_pkg.sv
// Shared encodings for the serial comparator: FSM states, running verdict,
// and a helper that turns a verdict into the one-hot {aeb, agb, alb} flags.
package cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    V_EQ = 2'd0,
    V_GT = 2'd1,
    V_LT = 2'd2
  } verdict_t;

  function automatic logic [2:0] verdictToFlags(input verdict_t v);
    logic [2:0] flags;
    flags = 3'b000;
    case (v)
      V_EQ:    flags = 3'b100;
      V_GT:    flags = 3'b010;
      V_LT:    flags = 3'b001;
      default: flags = 3'b000;
    endcase
    return flags;
  endfunction

endpackage

// File: rtl/comp1b.sv
// Single-bit magnitude comparator: exactly one of aeb/agb/alb is high.
module comp1b (
  input  logic a,
  input  logic b,
  output logic aeb,
  output logic agb,
  output logic alb
);

  assign aeb = ~(a ^ b);
  assign agb = a & ~b;
  assign alb = ~a & b;

endmodule

// File: rtl/serial_cmp_seq.sv
// Bit-serial N-bit magnitude comparator, MSB first. The first differing bit
// pair decides the verdict; the result is published with a one-cycle done.
module serial_cmp_seq
  import cmp_pkg::*;
#(
  parameter int N = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic clear,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic busy,
  output logic done,
  output logic aeb,
  output logic agb,
  output logic alb
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LastCnt = CW'(N - 1);

  state_t         r_state;
  verdict_t       r_verdict;
  logic [CW-1:0]  r_cnt;
  logic           r_busy;
  logic           r_done;
  logic [2:0]     r_flags;

  state_t         w_stateNext;
  verdict_t       w_verdictNext;
  verdict_t       w_verdictUpd;
  logic [CW-1:0]  w_cntNext;
  logic           w_doneNext;
  logic [2:0]     w_flagsNext;
  logic           w_aeb;
  logic           w_agb;
  logic           w_alb;

  comp1b u_comp1b (
    .a   (a_bit),
    .b   (b_bit),
    .aeb (w_aeb),
    .agb (w_agb),
    .alb (w_alb)
  );

  // Once the verdict leaves EQ it is frozen; only an EQ verdict looks at the bit pair.
  always_comb begin
    w_verdictUpd = r_verdict;
    if (r_verdict == V_EQ) begin
      case ({w_aeb, w_agb, w_alb})
        3'b010:  w_verdictUpd = V_GT;
        3'b001:  w_verdictUpd = V_LT;
        default: w_verdictUpd = V_EQ;
      endcase
    end
  end

  always_comb begin
    w_stateNext   = r_state;
    w_verdictNext = r_verdict;
    w_cntNext     = r_cnt;
    w_doneNext    = 1'b0;
    w_flagsNext   = r_flags;

    if (clear) begin
      w_stateNext   = ST_IDLE;
      w_verdictNext = V_EQ;
      w_cntNext     = '0;
      w_flagsNext   = 3'b000;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            w_stateNext   = ST_RUN;
            w_verdictNext = V_EQ;
            w_cntNext     = '0;
          end else begin
            w_stateNext = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (bit_valid) begin
            w_verdictNext = w_verdictUpd;
            w_cntNext     = r_cnt + 1'b1;
            if (r_cnt == LastCnt) begin
              w_stateNext = ST_DONE;
              w_doneNext  = 1'b1;
              w_flagsNext = verdictToFlags(w_verdictUpd);
            end
          end
        end
        default: begin
          w_stateNext   = ST_IDLE;
          w_verdictNext = V_EQ;
          w_cntNext     = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_verdict <= V_EQ;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_flags   <= 3'b000;
    end else begin
      r_state   <= w_stateNext;
      r_verdict <= w_verdictNext;
      r_cnt     <= w_cntNext;
      r_busy    <= (w_stateNext == ST_RUN);
      r_done    <= w_doneNext;
      r_flags   <= w_flagsNext;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign aeb  = r_flags[2];
  assign agb  = r_flags[1];
  assign alb  = r_flags[0];

endmodule
